// File: rtl/darkroom_sample_fifo.sv
// ============================================================================
// Module   : darkroom_sample_fifo
// Purpose  : Snapshots lighthouse sensor words on sync rising edges and
//            queues them round-robin into one FIFO drained over Avalon-MM.
//            Optional macro DARKROOM_FIFO_TIMESTAMP_EN adds cycle timestamps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module darkroom_sample_fifo #(
    parameter int NUMBER_OF_SENSORS = 8,
    parameter int FIFO_DEPTH_LOG2   = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data_i,
    input  logic [NUMBER_OF_SENSORS-1:0]    sync_i,
    input  logic [1:0]                      address,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     writedata,
    output logic [31:0]                     readdata,
    output logic                            waitrequest,
    output logic                            irq
);

    localparam int SEL_W = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
`ifdef DARKROOM_FIFO_TIMESTAMP_EN
    localparam int ENTRY_W = 64;
`else
    localparam int ENTRY_W = 32;
`endif

    logic [NUMBER_OF_SENSORS-1:0] sync_prev;
    logic [NUMBER_OF_SENSORS-1:0] capture;
    logic [NUMBER_OF_SENSORS-1:0] pending;
    logic [NUMBER_OF_SENSORS-1:0] grant_onehot;
    logic [31:0]                  snap [NUMBER_OF_SENSORS];
    logic [SEL_W-1:0]             rr_ptr;
    logic [SEL_W-1:0]             grant_idx;
    logic                         grant_valid;
    int                           arb_idx;

    logic                         push;
    logic                         pop;
    logic                         flush;
    logic                         clr_drop;
    logic                         full;
    logic                         empty;
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             count_next;
    logic [ENTRY_W-1:0]           mem [DEPTH];
    logic [ENTRY_W-1:0]           push_entry;
    logic [ENTRY_W-1:0]           head;

    logic [15:0]                  drop_cnt;
    logic                         overflow;
    logic [6:0]                   drop_num;
    logic [16:0]                  drop_sum;
    logic [31:0]                  count_ext;
    logic [7:0]                   count_disp;
    logic [31:0]                  status;

`ifdef DARKROOM_FIFO_TIMESTAMP_EN
    logic [31:0]                  ts;
    logic [31:0]                  ts_hold;
    logic [31:0]                  snap_ts [NUMBER_OF_SENSORS];
`endif

    wire unused_writedata = &{1'b0, writedata[31:2]};

    assign capture  = sync_i & ~sync_prev;
    assign flush    = write && (address == 2'd3) && writedata[0];
    assign clr_drop = write && (address == 2'd3) && writedata[1];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push     = grant_valid && !full && !flush;
    assign pop      = waitrequest && (address == 2'd1) && !empty;
    assign head     = mem[rd_ptr];

    // First pending sensor at or after rr_ptr, scanning with wrap-around
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int k = 0; k < NUMBER_OF_SENSORS; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUMBER_OF_SENSORS) begin
                arb_idx = arb_idx - NUMBER_OF_SENSORS;
            end
            if (!grant_valid && pending[arb_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = arb_idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (push) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

`ifdef DARKROOM_FIFO_TIMESTAMP_EN
    assign push_entry = {snap_ts[grant_idx], snap[grant_idx]};
`else
    assign push_entry = snap[grant_idx];
`endif

    // A capture onto a pending sensor is a drop unless that sensor is being pushed now
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
            if (capture[i] && pending[i] && !grant_onehot[i]) begin
                drop_num = drop_num + 7'd1;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_num);

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign count_ext  = 32'(count);
    assign count_disp = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];
    assign status     = {overflow, 7'b0, drop_cnt, count_disp};

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_prev <= '0;
            pending   <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            sync_prev <= sync_i;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (capture[i]) begin
                    snap[i] <= sensor_data_i[32*i +: 32];
                end
            end
            if (flush) begin
                pending <= '0;
            end else begin
                pending <= (pending & ~grant_onehot) | capture;
            end
            if (push) begin
                rr_ptr <= (grant_idx == SEL_W'(NUMBER_OF_SENSORS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

`ifdef DARKROOM_FIFO_TIMESTAMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts <= '0;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                snap_ts[i] <= '0;
            end
        end else begin
            ts <= ts + 32'd1;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (capture[i]) begin
                    snap_ts[i] <= ts;
                end
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            irq      <= 1'b0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_next;
            irq   <= (count_next != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (clr_drop) begin
                drop_cnt <= '0;
                overflow <= 1'b0;
            end else if (!flush && (drop_num != '0)) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    // Two-cycle read: waitrequest marks the cycle in which the access is performed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            waitrequest <= 1'b0;
            readdata    <= '0;
`ifdef DARKROOM_FIFO_TIMESTAMP_EN
            ts_hold     <= '0;
`endif
        end else if (!waitrequest) begin
            if (read) begin
                waitrequest <= 1'b1;
            end
        end else begin
            waitrequest <= 1'b0;
            case (address)
                2'd0: readdata <= status;
                2'd1: begin
                    readdata <= empty ? 32'h0 : head[31:0];
`ifdef DARKROOM_FIFO_TIMESTAMP_EN
                    ts_hold  <= empty ? 32'h0 : head[63:32];
`endif
                end
`ifdef DARKROOM_FIFO_TIMESTAMP_EN
                2'd2: readdata <= ts_hold;
`else
                2'd2: readdata <= 32'h0;
`endif
                default: readdata <= 32'(NUMBER_OF_SENSORS);
            endcase
        end
    end

endmodule

`default_nettype wire
